// File: rtl/audio_pkg.sv
// Shared types and constants for the gain/ramp audio datapath.
//   DEF_*      : default parameter values used by the modules
//   sample_t   : one signed sample at the default width
//   state_e    : frame sequencer states
//   UNITY_GAIN : gain code equal to 1.0
//   SAT_MAX/MIN: clip limits of a default-width sample
//   sat()      : clip a signed value into a w-bit signed range
package audio_pkg;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_NCH    = 2;
  localparam int DEF_GAIN_W = 8;
  localparam int DEF_FRAC_W = 6;
  localparam int DEF_RAMP_W = 4;

  localparam int UNITY_GAIN = 1 << DEF_FRAC_W;

  typedef logic signed [DEF_DATA_W-1:0] sample_t;

  localparam sample_t SAT_MAX = {1'b0, {(DEF_DATA_W-1){1'b1}}};
  localparam sample_t SAT_MIN = {1'b1, {(DEF_DATA_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MUL1, MUL2, WAIT_OUT} state_e;

  // Result is sign-extended to 64 bits; callers keep the low w bits.
  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    if (v > hi)      return hi;
    else if (v < lo) return lo;
    else             return v;
  endfunction
endpackage

// File: rtl/audio_chan_mul.sv
// One channel's multiply / shift / saturate pipeline.
//   clk, rst_n : clock, async active-low reset
//   mul_en     : capture sample * g_eff into the wide product register
//   sat_en     : capture floor(product / 2^FRAC_W), clipped to DATA_W
//   sample     : signed input sample (held stable by the top)
//   g_eff      : unsigned effective gain (gain scaled by ramp)
//   res        : registered, saturated result
module audio_chan_mul import audio_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int GAIN_W = DEF_GAIN_W,
  parameter int FRAC_W = DEF_FRAC_W
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mul_en,
  input  logic                     sat_en,
  input  logic signed [DATA_W-1:0] sample,
  input  logic        [GAIN_W-1:0] g_eff,
  output logic signed [DATA_W-1:0] res
);
  localparam int PW = DATA_W + GAIN_W + 1;

  logic signed [PW-1:0]     p_q, p_d, s_ext, g_ext;
  logic signed [DATA_W-1:0] r_q, r_d;
  logic signed [63:0]       shifted;

  always_comb begin
    p_d   = p_q;
    r_d   = r_q;
    // gain is unsigned: zero-extend it before treating it as signed
    s_ext = PW'(sample);
    g_ext = PW'($signed({1'b0, g_eff}));
    // arithmetic shift floors toward -inf
    shifted = 64'(p_q) >>> FRAC_W;
    if (mul_en) p_d = s_ext * g_ext;
    if (sat_en) r_d = DATA_W'(sat(shifted, DATA_W));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_q <= '0;
      r_q <= '0;
    end else begin
      p_q <= p_d;
      r_q <= r_d;
    end
  end

  assign res = r_q;
endmodule

// File: rtl/audio_gain_ramp.sv
// Multi-channel gain stage with saturation and a soft-mute ramp,
// sitting between the codec FIFO handshake and the board controls.
//   CLOCK_50, reset_n        : clock, async active-low reset
//   audio_in_available       : codec has an input frame
//   audio_out_allowed        : codec can accept an output frame
//   audio_in / audio_out     : NCH packed samples, ch c at [c*DATA_W +: DATA_W]
//   gain                     : unsigned fixed-point gain, FRAC_W fraction bits
//   mute                     : 1 ramps toward silence, 0 toward gain
//   read_audio_in            : one-cycle strobe after a capture
//   write_audio_out          : one-cycle strobe when audio_out loads
//   ramp_level               : current ramp position, 0..2^RAMP_W
//   busy                     : frame in flight
module audio_gain_ramp import audio_pkg::*; #(
  parameter int DATA_W = DEF_DATA_W,
  parameter int NCH    = DEF_NCH,
  parameter int GAIN_W = DEF_GAIN_W,
  parameter int FRAC_W = DEF_FRAC_W,
  parameter int RAMP_W = DEF_RAMP_W
) (
  input  logic                  CLOCK_50,
  input  logic                  reset_n,
  input  logic                  audio_in_available,
  input  logic                  audio_out_allowed,
  input  logic [NCH*DATA_W-1:0] audio_in,
  input  logic [GAIN_W-1:0]     gain,
  input  logic                  mute,
  output logic                  read_audio_in,
  output logic                  write_audio_out,
  output logic [NCH*DATA_W-1:0] audio_out,
  output logic [RAMP_W:0]       ramp_level,
  output logic                  busy
);
  localparam logic [RAMP_W:0] RAMP_FULL = {1'b1, {RAMP_W{1'b0}}};

  state_e                  state_q, state_d;
  logic [NCH*DATA_W-1:0]   in_q, in_d, out_q, out_d, res;
  logic [GAIN_W-1:0]       geff_q, geff_d;
  logic [RAMP_W:0]         ramp_q, ramp_d;
  logic [GAIN_W+RAMP_W:0]  gprod;
  logic                    mute_q, mute_d, rd_q, rd_d, wr_q, wr_d, busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    in_d    = in_q;
    out_d   = out_q;
    geff_d  = geff_q;
    mute_d  = mute_q;
    ramp_d  = ramp_q;
    rd_d    = 1'b0;
    wr_d    = 1'b0;
    gprod   = {{(RAMP_W+1){1'b0}}, gain} * {{GAIN_W{1'b0}}, ramp_q};
    case (state_q)
      IDLE: if (audio_in_available) begin
        // everything the frame needs is frozen here, so later control
        // changes cannot reach the in-flight frame
        in_d    = audio_in;
        geff_d  = GAIN_W'(gprod >> RAMP_W);
        mute_d  = mute;
        rd_d    = 1'b1;
        state_d = MUL1;
      end
      MUL1:     state_d = MUL2;
      MUL2:     state_d = WAIT_OUT;
      WAIT_OUT: if (audio_out_allowed) begin
        out_d   = res;
        wr_d    = 1'b1;
        state_d = IDLE;
        // saturating ramp step, one per written frame
        if (mute_q && ramp_q != '0)             ramp_d = ramp_q - 1'b1;
        else if (!mute_q && ramp_q != RAMP_FULL) ramp_d = ramp_q + 1'b1;
      end
      default:  state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      in_q    <= '0;
      out_q   <= '0;
      geff_q  <= '0;
      mute_q  <= 1'b0;
      ramp_q  <= '0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      in_q    <= in_d;
      out_q   <= out_d;
      geff_q  <= geff_d;
      mute_q  <= mute_d;
      ramp_q  <= ramp_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      busy_q  <= busy_d;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    audio_chan_mul #(.DATA_W(DATA_W), .GAIN_W(GAIN_W), .FRAC_W(FRAC_W)) u_mul (
      .clk    (CLOCK_50),
      .rst_n  (reset_n),
      .mul_en (state_q == MUL1),
      .sat_en (state_q == MUL2),
      .sample (in_q[c*DATA_W +: DATA_W]),
      .g_eff  (geff_q),
      .res    (res[c*DATA_W +: DATA_W])
    );
  end

  assign read_audio_in   = rd_q;
  assign write_audio_out = wr_q;
  assign audio_out       = out_q;
  assign ramp_level      = ramp_q;
  assign busy            = busy_q;
endmodule
